// File: rtl/instr_encoder.sv
// Packs symbolic MIPS instructions into 32-bit words and streams them into
// consecutive instruction-memory word addresses, one word per accepted request.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] PTR_END  = '1;

  // LAST is the strobe cycle of the final address: write and full at once.
  typedef enum logic [1:0] {IDLE, WRITE, LAST, FULL} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              accept, legal, take;

  function automatic logic [31:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    case (op)
      4'd0:    word = {6'h00, rs, rt, rd, 5'h00, 6'h20};
      4'd1:    word = {6'h00, rs, rt, rd, 5'h00, 6'h22};
      4'd2:    word = {6'h00, rs, rt, rd, 5'h00, 6'h24};
      4'd3:    word = {6'h00, rs, rt, rd, 5'h00, 6'h25};
      4'd4:    word = {6'h00, rs, rt, rd, 5'h00, 6'h2A};
      4'd5:    word = {6'h08, rs, rt, imm};
      4'd6:    word = {6'h0C, rs, rt, imm};
      4'd7:    word = {6'h23, rs, rt, imm};
      4'd8:    word = {6'h2B, rs, rt, imm};
      4'd9:    word = {6'h04, rs, rt, imm};
      4'd10:   word = {6'h05, rs, rt, imm};
      4'd11:   word = {6'h02, target};
      default: word = 32'h0;
    endcase
    return word;
  endfunction

  assign legal  = (in_op <= 4'd11);
  assign accept = in_valid && in_ready;
  assign take   = accept && legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (take)
      state_nxt = (ptr == PTR_END) ? LAST : WRITE;
    else if (!clear && (state == LAST || state == FULL))
      state_nxt = FULL;
  end

  always_comb begin
    imem_we  = (state == WRITE) || (state == LAST);
    full     = (state == LAST) || (state == FULL);
    in_ready = !full && !clear;
  end

  // Registered write port; address/data hold between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= PTR_BASE;
      count      <= '0;
      err        <= 1'b0;
      imem_addr  <= PTR_BASE;
      imem_wdata <= 32'h0;
    end else if (clear) begin
      ptr   <= PTR_BASE;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (take) begin
        imem_addr  <= ptr;
        imem_wdata <= encode(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
        ptr        <= ptr + 1'b1;
        count      <= count + 1'b1;
      end
      if (accept && !legal)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus random traffic checked
// against a cycle-level reference model of the loader.
module tb_instr_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  localparam int OPC [0:11] = '{0, 0, 0, 0, 0, 8, 12, 35, 43, 4, 5, 2};
  localparam int FN  [0:4]  = '{32, 34, 36, 37, 42};

  logic          clk, reset, clear, in_valid, in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full, err;

  int tests = 0;
  int fails = 0;

  int          m_ptr, m_count;
  bit          m_full, m_err, m_we;
  logic [31:0] m_addr, m_wdata;

  instr_encoder #(.ADDR_W(AW), .BASE(0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(int op, int rs, int rt, int rd, int imm, int tgt);
    longint w;
    if (op < 5)       w = longint'(rs) * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + FN[op];
    else if (op < 11) w = longint'(OPC[op]) * (longint'(1) << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
    else              w = longint'(2) * (longint'(1) << 26) + tgt;
    return 32'(w);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_we"},    32'(imem_we),    32'(m_we));
    check({tag, "_addr"},  32'(imem_addr),  m_addr);
    check({tag, "_wdata"}, imem_wdata,      m_wdata);
    check({tag, "_count"}, 32'(count),      32'(m_count));
    check({tag, "_full"},  32'(full),       32'(m_full));
    check({tag, "_err"},   32'(err),        32'(m_err));
  endtask

  task automatic model_reset();
    m_ptr = 0; m_count = 0; m_full = 0; m_err = 0; m_we = 0;
    m_addr = 0; m_wdata = 0;
  endtask

  // Asserted between edges so the asynchronous response is visible at once.
  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; clear = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    check("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cycle(input bit v, input int op, input int rs, input int rt, input int rd,
                       input int imm, input int tgt, input bit clr);
    bit acc;
    @(negedge clk);
    in_valid = v; in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_target = 26'(tgt); clear = clr;
    #1;
    check("ready", 32'(in_ready), 32'(!m_full && !clr));
    acc = v && !m_full && !clr;
    @(posedge clk);
    m_we = 0;
    if (clr) begin
      m_ptr = 0; m_count = 0; m_full = 0; m_err = 0;
    end else if (acc && op < 12) begin
      m_we = 1; m_addr = 32'(m_ptr);
      m_wdata = model_word(op, rs, rt, rd, imm, tgt);
      m_ptr++; m_count++;
      if (m_ptr == DEPTH) m_full = 1;
    end else if (acc) begin
      m_err = 1;
    end
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_op = '0; in_rs = '0;
    in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    do_reset();

    cycle(1, 0, 1, 2, 3, 0, 0, 0);
    check("add_word", imem_wdata, 32'h00221820);
    check("add_addr", 32'(imem_addr), 32'd0);
    check("add_count", 32'(count), 32'd1);
    cycle(1, 5, 1, 2, 9, 5, 0, 0);
    check("addi_word", imem_wdata, 32'h20220005);
    check("addi_addr", 32'(imem_addr), 32'd1);

    do_reset();
    cycle(1, 7, 29, 8, 0, 4, 0, 0);
    check("lw_word", imem_wdata, 32'h8FA80004);
    check("lw_we", 32'(imem_we), 32'd1);
    cycle(1, 9, 1, 2, 31, 16'hFFFF, 0, 0);
    check("beq_word", imem_wdata, 32'h1022FFFF);
    check("beq_addr", 32'(imem_addr), 32'd1);
    cycle(1, 11, 7, 7, 7, 16'h1234, 32'h10, 0);
    check("j_word", imem_wdata, 32'h08000010);
    check("j_addr", 32'(imem_addr), 32'd2);
    idle_cycle();

    do_reset();
    cycle(1, 0, 1, 2, 3, 0, 0, 0);
    cycle(1, 13, 1, 2, 3, 0, 0, 0);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_we", 32'(imem_we), 32'd0);
    cycle(1, 1, 4, 5, 6, 0, 0, 0);
    check("after_illegal_addr", 32'(imem_addr), 32'd1);
    check("after_illegal_err", 32'(err), 32'd1);

    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 3, i, i + 1, i + 2, 0, 0, 0);
    check("fill_count", 32'(count), 32'd4);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ready", 32'(in_ready), 32'd0);
    cycle(1, 2, 1, 1, 1, 0, 0, 1);
    check("clr_full", 32'(full), 32'd0);
    check("clr_count", 32'(count), 32'd0);
    cycle(1, 4, 9, 10, 11, 0, 0, 0);
    check("clr_next_addr", 32'(imem_addr), 32'd0);
    check("clr_next_we", 32'(imem_we), 32'd1);

    cycle(1, 6, 3, 4, 5, 16'hBEEF, 0, 0);
    do_reset();
    check("rst_mid_we", 32'(imem_we), 32'd0);
    cycle(1, 8, 2, 3, 0, 16'h0010, 0, 0);
    check("post_rst_addr", 32'(imem_addr), 32'd0);

    for (int i = 0; i < 400; i++) begin
      int op;
      op = ($urandom_range(0, 9) == 0) ? 12 + $urandom_range(0, 3) : $urandom_range(0, 11);
      cycle($urandom_range(0, 3) != 0, op, $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 26'h3FFFFFF),
            $urandom_range(0, 19) == 0);
      if (i == 200) begin
        cycle(1, 0, 1, 1, 1, 0, 0, 1);
        cycle(1, 10, 3, 3, 3, 16'h8000, 0, 0);
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
